row_adc_ctrl: RTL and testbench
===============================

ROW_ADC_CTRL -- requirements
Module: row_adc_ctrl

Interface
REQ-001 Parameter COLUMNS, default 2, number of column comparators/samples per row.
REQ-002 Parameter BITS, default 8, ramp/sample resolution; ramp length 2**BITS cycles.
REQ-003 Port clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port adc_enable  input  1  row-conversion request from pixel controller, held high until done seen.
REQ-006 Port cmp  input  COLUMNS  per-column comparator outputs, 1 = ramp has passed pixel level.
REQ-007 Port ramp_code  output  BITS  code driven to ramp DAC.
REQ-008 Port ramp_active  output  1  high while ramp is running.
REQ-009 Port out_valid  output  1  sample available.
REQ-010 Port out_ready  input  1  downstream accepts sample.
REQ-011 Port out_column  output  $clog2(COLUMNS) (min 1)  column index of current sample.
REQ-012 Port out_data  output  BITS  converted value of current sample.
REQ-013 Port done  output  1  row conversion and readout complete.

Function
REQ-014 FSM states IDLE, RAMP, READOUT, DONE; registered outputs only.
REQ-015 IDLE: ramp_code=0, ramp_active=0, out_valid=0, done=0; adc_enable=1 -> RAMP next cycle, all column latches cleared to "not tripped".
REQ-016 RAMP: ramp_active=1; ramp_code starts at 0 in first RAMP cycle, +1 per cycle.
REQ-017 RAMP: in each cycle, for each column i not yet tripped with cmp[i]=1, latch sample[i]=ramp_code of that cycle and mark tripped; later cmp[i] changes ignored.
REQ-018 Column never tripped by end of ramp -> sample[i]=2**BITS-1 (saturate).
REQ-019 Cycle with ramp_code=2**BITS-1 is last RAMP cycle (comparator still sampled); next state READOUT, ramp_code returns 0, ramp_active=0; no wrap-around.
REQ-020 READOUT: out_valid=1, out_column starts 0, out_data=sample[out_column]; out_column/out_data stable while out_valid && !out_ready.
REQ-021 Transfer on out_valid && out_ready; out_column increments; transfer of column COLUMNS-1 -> DONE, out_valid=0 next cycle.
REQ-022 Latency: adc_enable high in IDLE to first out_valid = 2**BITS+1 cycles.
REQ-023 DONE: done=1, held until adc_enable=0 sampled; then IDLE with done=0 next cycle.
REQ-024 adc_enable=0 in RAMP or READOUT -> abort to IDLE next cycle, samples discarded, done not asserted.
REQ-025 adc_enable=1 continuously after done is not a new request; a new conversion requires adc_enable low for at least one cycle.
REQ-026 Simultaneous trip of multiple columns in one cycle -> all latch the same code.

Reset
REQ-027 reset=1 at a clock edge -> IDLE; ramp_code=0, ramp_active=0, out_valid=0, out_column=0, out_data=0, done=0, all latches cleared.
REQ-028 Reset mid-RAMP/READOUT/DONE abandons the row; no further samples emitted until new adc_enable.
REQ-029 Reset has priority over every other input in the same cycle.

Structure
REQ-030 Shared package holds state enum (IDLE, RAMP, READOUT, DONE) and default COLUMNS/BITS constants, shared with pixel controller.
REQ-031 One sub-module column_latch (tripped flag + BITS-bit sample, clear/capture inputs), instanced COLUMNS times by generate.

Verification
REQ-032 BITS=8, COLUMNS=2; cmp[0] rises at ramp_code=37, cmp[1] at 200, out_ready=1 -> outputs (0,37),(1,200); done at cycle 259 after request.
REQ-033 cmp[1] never rises, cmp[0] high from ramp_code=0 -> samples 0 and 255.
REQ-034 out_ready low 5 cycles on column 0 -> out_valid/out_column/out_data held, no sample lost or duplicated.
REQ-035 adc_enable dropped at ramp_code=100 -> IDLE next cycle, out_valid never asserted, done stays 0; next request converts normally.
REQ-036 reset asserted in READOUT after column 0 accepted -> all outputs 0 next cycle; adc_enable held high then restarts conversion only after one low cycle.
REQ-037 cmp[0] glitches high at 50, low at 51, high at 90 -> sample 50 (first trip only).

Source files
------------

// File: rtl/row_adc_ctrl_pkg.sv
// Shared definitions for the row ADC controller and the pixel controller.
// Holds the conversion state encoding and the default array geometry.
// No logic; constants and one width helper only.
package row_adc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP    = 2'd1,
        READOUT = 2'd2,
        DONE    = 2'd3
    } adc_state_t;

    localparam int DEF_COLUMNS = 2;
    localparam int DEF_BITS    = 8;

    // Column index width; a single-column build still gets a 1-bit index.
    function automatic int col_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/row_adc_ctrl_column_latch.sv
// Per-column single-slope capture: tripped flag plus the ramp code at first trip.
// Latency: capture lands at the edge ending the trip cycle; sample also forwards it same-cycle.
// Backpressure: none; clear/capture are driven by the controller FSM.
module column_latch #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            capture,
    input  logic            cmp,
    input  logic [BITS-1:0] code,
    output logic [BITS-1:0] sample
);

    logic            tripped;
    logic [BITS-1:0] sample_q;
    logic            hit;

    // Only the first comparator assertion during a ramp counts.
    assign hit    = capture && !tripped && cmp;
    // Forward a capture happening this cycle so the controller can register
    // the final value on the same edge that ends the ramp.
    assign sample = hit ? code : sample_q;

    // Clear preloads the saturated code so an untripped column reads full scale.
    always_ff @(posedge clk) begin
        if (reset) begin
            tripped  <= 1'b0;
            sample_q <= '0;
        end else if (clear) begin
            tripped  <= 1'b0;
            sample_q <= '1;
        end else if (hit) begin
            tripped  <= 1'b1;
            sample_q <= code;
        end
    end

endmodule

// File: rtl/row_adc_ctrl.sv
// Row ADC controller: runs one 2**BITS-step ramp, latches per-column codes, reads them out.
// Latency: first out_valid 2**BITS+1 cycles after a fresh adc_enable request in IDLE.
// Backpressure: out_valid/out_ready handshake; column and data hold while out_ready is low.
module row_adc_ctrl
    import row_adc_ctrl_pkg::*;
#(
    parameter int COLUMNS = DEF_COLUMNS,
    parameter int BITS    = DEF_BITS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           adc_enable,
    input  logic [COLUMNS-1:0]             cmp,
    output logic [BITS-1:0]                ramp_code,
    output logic                           ramp_active,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [col_width(COLUMNS)-1:0]  out_column,
    output logic [BITS-1:0]                out_data,
    output logic                           done
);

    localparam int              CW       = col_width(COLUMNS);
    localparam logic [BITS-1:0] CODE_MAX = '1;
    localparam logic [CW-1:0]   LAST_COL = CW'(COLUMNS - 1);

    adc_state_t      state;
    logic            armed;
    logic            start;
    logic            lat_clear;
    logic            lat_capture;
    logic [CW-1:0]   next_col;
    logic [BITS-1:0] lat_sample [COLUMNS];

    // A request only counts once adc_enable has been seen low since the last
    // row or reset, so a level held high across done never re-triggers.
    assign start       = (state == IDLE) && adc_enable && armed;
    assign lat_clear   = start;
    assign lat_capture = (state == RAMP);
    assign next_col    = out_column + 1'b1;

    for (genvar i = 0; i < COLUMNS; i++) begin : g_col
        column_latch #(
            .BITS(BITS)
        ) u_latch (
            .clk     (clk),
            .reset   (reset),
            .clear   (lat_clear),
            .capture (lat_capture),
            .cmp     (cmp[i]),
            .code    (ramp_code),
            .sample  (lat_sample[i])
        );
    end

    // Conversion sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            armed       <= 1'b0;
            ramp_code   <= '0;
            ramp_active <= 1'b0;
            out_valid   <= 1'b0;
            out_column  <= '0;
            out_data    <= '0;
            done        <= 1'b0;
        end else begin
            if (!adc_enable) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RAMP;
                        armed       <= 1'b0;
                        ramp_code   <= '0;
                        ramp_active <= 1'b1;
                    end
                end
                RAMP: begin
                    if (!adc_enable) begin
                        state       <= IDLE;
                        ramp_code   <= '0;
                        ramp_active <= 1'b0;
                    end else if (ramp_code == CODE_MAX) begin
                        state       <= READOUT;
                        ramp_code   <= '0;
                        ramp_active <= 1'b0;
                        out_valid   <= 1'b1;
                        out_column  <= '0;
                        out_data    <= lat_sample[0];
                    end else begin
                        ramp_code <= ramp_code + 1'b1;
                    end
                end
                READOUT: begin
                    if (!adc_enable) begin
                        state      <= IDLE;
                        out_valid  <= 1'b0;
                        out_column <= '0;
                        out_data   <= '0;
                    end else if (out_ready) begin
                        if (out_column == LAST_COL) begin
                            state      <= DONE;
                            out_valid  <= 1'b0;
                            out_column <= '0;
                            out_data   <= '0;
                            done       <= 1'b1;
                        end else begin
                            out_column <= next_col;
                            out_data   <= lat_sample[next_col];
                        end
                    end
                end
                DONE: begin
                    if (!adc_enable) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_adc_ctrl.sv
// Bench for row_adc_ctrl: randomized comparator patterns, a first-trip reference
// model feeding an expected-sample queue, and a separate readout monitor.
module tb_row_adc_ctrl;

    localparam int NCOL = 2;
    localparam int NB   = 8;
    localparam int RLEN = 1 << NB;

    logic            clk;
    logic            reset;
    logic            adc_enable;
    logic [NCOL-1:0] cmp;
    logic [NB-1:0]   ramp_code;
    logic            ramp_active;
    logic            out_valid;
    logic            out_ready;
    logic [0:0]      out_column;
    logic [NB-1:0]   out_data;
    logic            done;

    row_adc_ctrl #(
        .COLUMNS (NCOL),
        .BITS    (NB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .adc_enable  (adc_enable),
        .cmp         (cmp),
        .ramp_code   (ramp_code),
        .ramp_active (ramp_active),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_column  (out_column),
        .out_data    (out_data),
        .done        (done)
    );

    typedef struct {
        int col;
        int data;
    } exp_t;

    exp_t          exp_q[$];
    logic [RLEN-1:0] pat [NCOL];
    int            vectors     = 0;
    int            miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Comparator goes high at ramp step thr and stays high; noisy adds random
    // drop-outs after the first trip, which the DUT must ignore.
    task automatic set_thr(input int i, input int thr, input bit noisy);
        pat[i] = '0;
        for (int k = 0; k < RLEN; k++) begin
            if (k >= thr) pat[i][k] = noisy ? ((k == thr) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b1;
        end
    endtask

    // Readout monitor: scoreboard pop on each transfer, hold check on stalls.
    logic          pv, pr;
    int            pc, pd;
    initial begin
        pv = 1'b0; pr = 1'b0; pc = 0; pd = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (out_valid && pv && !pr) begin
                    chk("hold_column", int'(out_column), pc);
                    chk("hold_data", int'(out_data), pd);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_sample: column %0d data %0d, none expected", out_column, out_data);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("out_column", int'(out_column), e.col);
                        chk("out_data", int'(out_data), e.data);
                    end
                end
            end
            pv = out_valid; pr = out_ready; pc = int'(out_column); pd = int'(out_data);
        end
    end

    // One row: abort_at >= 0 drops adc_enable at that ramp code; rst_mid resets
    // after column 0 is accepted; stall0 holds out_ready low at readout start.
    task automatic convert(input int abort_at, input int stall0, input bit rnd_rdy, input bit rst_mid);
        int   expv[NCOL];
        int   cyc;
        exp_t e;
        for (int i = 0; i < NCOL; i++) begin
            expv[i] = RLEN - 1;
            for (int k = RLEN - 1; k >= 0; k--) if (pat[i][k]) expv[i] = k;
        end
        adc_enable = 1'b1;
        cmp        = '0;
        out_ready  = 1'b0;
        step();
        for (int k = 0; k < RLEN; k++) begin
            chk("ramp_active", int'(ramp_active), 1);
            chk("ramp_code", int'(ramp_code), k);
            chk("valid_in_ramp", int'(out_valid), 0);
            for (int i = 0; i < NCOL; i++) cmp[i] = pat[i][k];
            if (k == abort_at) adc_enable = 1'b0;
            step();
            if (k == abort_at) begin
                cmp = '0;
                chk("abort_ramp_active", int'(ramp_active), 0);
                chk("abort_ramp_code", int'(ramp_code), 0);
                for (int j = 0; j < 4; j++) begin
                    chk("abort_valid", int'(out_valid), 0);
                    chk("abort_done", int'(done), 0);
                    step();
                end
                return;
            end
        end
        cmp = '0;
        for (int i = 0; i < NCOL; i++) begin
            e.col = i; e.data = expv[i];
            exp_q.push_back(e);
        end
        chk("latency_valid", int'(out_valid), 1);
        chk("end_ramp_active", int'(ramp_active), 0);
        chk("end_ramp_code", int'(ramp_code), 0);
        if (rst_mid) begin
            out_ready = 1'b1;
            step();
            chk("col_after_accept", int'(out_column), 1);
            out_ready = 1'b0;
            reset     = 1'b1;
            step();
            reset = 1'b0;
            chk("rst_valid", int'(out_valid), 0);
            chk("rst_column", int'(out_column), 0);
            chk("rst_data", int'(out_data), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_ramp_active", int'(ramp_active), 0);
            chk("rst_pending", exp_q.size(), 1);
            exp_q.delete();
            for (int j = 0; j < 6; j++) begin
                step();
                chk("held_en_no_start", int'(ramp_active), 0);
                chk("held_en_no_valid", int'(out_valid), 0);
            end
            adc_enable = 1'b0;
            step();
            return;
        end
        cyc = 0;
        while (!done && cyc < 64) begin
            out_ready = (cyc < stall0) ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 2) != 0) : 1'b1);
            step();
            cyc++;
        end
        out_ready = 1'b0;
        chk("done_seen", int'(done), 1);
        if (!rnd_rdy) chk("done_cycle", cyc, stall0 + NCOL);
        chk("all_samples_out", exp_q.size(), 0);
        for (int j = 0; j < 3; j++) begin
            step();
            chk("done_held", int'(done), 1);
            chk("no_retrigger", int'(ramp_active), 0);
        end
        adc_enable = 1'b0;
        step();
        chk("done_cleared", int'(done), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; adc_enable = 1'b1; cmp = '0; out_ready = 1'b0;
        repeat (3) step();
        chk("reset_ramp_code", int'(ramp_code), 0);
        chk("reset_ramp_active", int'(ramp_active), 0);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_column", int'(out_column), 0);
        chk("reset_data", int'(out_data), 0);
        chk("reset_done", int'(done), 0);
        reset = 1'b0;
        repeat (2) begin
            step();
            chk("no_start_held_high", int'(ramp_active), 0);
        end
        adc_enable = 1'b0;
        step();

        set_thr(0, 37, 1'b0); set_thr(1, 200, 1'b0);
        convert(-1, 0, 1'b0, 1'b0);
        set_thr(0, 0, 1'b0);  set_thr(1, RLEN, 1'b0);
        convert(-1, 0, 1'b0, 1'b0);
        set_thr(0, 77, 1'b1); set_thr(1, 12, 1'b1);
        convert(-1, 5, 1'b0, 1'b0);
        set_thr(0, 20, 1'b0); set_thr(1, 150, 1'b0);
        convert(100, 0, 1'b0, 1'b0);
        set_thr(0, 64, 1'b0); set_thr(1, 255, 1'b0);
        convert(-1, 0, 1'b0, 1'b0);
        set_thr(0, 10, 1'b0); set_thr(1, 180, 1'b0);
        convert(-1, 0, 1'b0, 1'b1);
        set_thr(0, 90, 1'b0); pat[0][50] = 1'b1; set_thr(1, 123, 1'b0);
        convert(-1, 0, 1'b0, 1'b0);
        set_thr(0, 123, 1'b1); set_thr(1, 123, 1'b1);
        convert(-1, 0, 1'b1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NCOL; i++) set_thr(i, int'($urandom_range(0, 299)), 1'b1);
            convert(-1, int'($urandom_range(0, 3)), 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
